// File: rtl/trace_pkg.sv
// Shared types for the commit trace checker: record layout, commit kinds,
// mismatch flag positions and checker FSM states.
package trace_pkg;

  // Width of one golden trace record.
  localparam int REC_W = 55;

  // Bit positions of each field inside a packed golden record.
  localparam int KIND_MSB  = 54;
  localparam int KIND_LSB  = 52;
  localparam int PC_MSB    = 51;
  localparam int PC_LSB    = 36;
  localparam int REG_MSB   = 35;
  localparam int REG_LSB   = 32;
  localparam int VALUE_MSB = 31;
  localparam int VALUE_LSB = 16;
  localparam int ADDR_MSB  = 15;
  localparam int ADDR_LSB  = 0;

  // Positions inside the 5-bit field-mismatch vector {addr, value, reg, pc, kind}.
  localparam int FLAG_KIND  = 0;
  localparam int FLAG_PC    = 1;
  localparam int FLAG_REG   = 2;
  localparam int FLAG_VALUE = 3;
  localparam int FLAG_ADDR  = 4;
  localparam int FLAG_W     = 5;

  // Commit kinds. END only ever appears in the golden trace and marks its end.
  typedef enum logic [2:0] {
    KIND_NOP  = 3'd0,
    KIND_REG  = 3'd1,
    KIND_LD   = 3'd2,
    KIND_ST   = 3'd3,
    KIND_HALT = 3'd4,
    KIND_END  = 3'd5
  } kind_e;

  // Decoded golden record. Field order matches the packed memory layout.
  typedef struct packed {
    logic [2:0]  kind;
    logic [15:0] pc;
    logic [3:0]  rd;
    logic [15:0] value;
    logic [15:0] addr;
  } trace_rec_t;

  // Checker FSM states.
  typedef enum logic [1:0] {
    ST_PRIME0 = 2'd0,
    ST_PRIME1 = 2'd1,
    ST_ARMED  = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  // Split a raw memory word into named record fields.
  function automatic trace_rec_t unpack_rec(input logic [REC_W-1:0] raw);
    trace_rec_t rec;
    rec.kind  = raw[KIND_MSB:KIND_LSB];
    rec.pc    = raw[PC_MSB:PC_LSB];
    rec.rd    = raw[REG_MSB:REG_LSB];
    rec.value = raw[VALUE_MSB:VALUE_LSB];
    rec.addr  = raw[ADDR_MSB:ADDR_LSB];
    return rec;
  endfunction

endpackage

// File: rtl/trace_rec_compare.sv
// Combinational compare of one expected golden record against one CPU commit.
// Produces the field-mismatch vector {addr, value, reg, pc, kind}.
module trace_rec_compare
  import trace_pkg::*;
(
  input  trace_rec_t        i_rec,
  input  logic [2:0]        i_kind,
  input  logic [15:0]       i_pc,
  input  logic [3:0]        i_reg,
  input  logic [15:0]       i_value,
  input  logic [15:0]       i_addr,
  output logic [FLAG_W-1:0] o_mismatch
);

  logic w_cmp_reg;
  logic w_cmp_value;
  logic w_cmp_addr;

  // Select which payload fields are meaningful for the expected kind.
  always_comb begin
    w_cmp_reg   = 1'b0;
    w_cmp_value = 1'b0;
    w_cmp_addr  = 1'b0;
    case (i_rec.kind)
      KIND_REG: begin
        w_cmp_reg   = 1'b1;
        w_cmp_value = 1'b1;
      end
      KIND_LD: begin
        w_cmp_reg   = 1'b1;
        w_cmp_value = 1'b1;
        w_cmp_addr  = 1'b1;
      end
      KIND_ST: begin
        w_cmp_value = 1'b1;
        w_cmp_addr  = 1'b1;
      end
      default: begin
        w_cmp_reg   = 1'b0;
        w_cmp_value = 1'b0;
        w_cmp_addr  = 1'b0;
      end
    endcase
  end

  // Build the mismatch flags; only kinds NOP..HALT can ever match a commit.
  always_comb begin
    o_mismatch             = '0;
    o_mismatch[FLAG_KIND]  = (i_rec.kind != i_kind) || (i_rec.kind > KIND_HALT);
    o_mismatch[FLAG_PC]    = (i_rec.pc != i_pc);
    o_mismatch[FLAG_REG]   = w_cmp_reg   && (i_rec.rd    != i_reg);
    o_mismatch[FLAG_VALUE] = w_cmp_value && (i_rec.value != i_value);
    o_mismatch[FLAG_ADDR]  = w_cmp_addr  && (i_rec.addr  != i_addr);
  end

endmodule

// File: rtl/commit_trace_checker.sv
// Commit trace checker: walks a golden trace in a synchronous-read memory in
// lock-step with the CPU commit stream and reports pass/fail at halt, keeping
// the first mismatch for debug.
module commit_trace_checker
  import trace_pkg::*;
#(
  parameter int AW           = 10,
  parameter bit STOP_ON_FAIL = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              commit_valid,
  output logic              commit_ready,
  input  logic [2:0]        commit_kind,
  input  logic [15:0]       commit_pc,
  input  logic [3:0]        commit_reg,
  input  logic [15:0]       commit_value,
  input  logic [15:0]       commit_addr,
  output logic [AW-1:0]     gold_addr,
  input  logic [REC_W-1:0]  gold_data,
  output logic              done,
  output logic              pass,
  output logic              fail,
  output logic [15:0]       inst_count,
  output logic [15:0]       err_count,
  output logic [15:0]       fail_index,
  output logic [4:0]        fail_field
);

  state_e            r_state;
  trace_rec_t        r_rec;
  logic [AW-1:0]     r_idx;
  logic [15:0]       r_inst_count;
  logic [15:0]       r_err_count;
  logic [15:0]       r_fail_index;
  logic [FLAG_W-1:0] r_fail_field;
  logic              r_fail;

  logic              w_accept;
  logic              w_idx_full;
  logic              w_is_halt;
  logic              w_mismatch;
  logic [FLAG_W-1:0] w_field_mm;
  logic [FLAG_W-1:0] w_mm_vec;
  logic [AW-1:0]     w_gold_addr;

  assign commit_ready = (r_state == ST_ARMED) || (r_state == ST_DONE);
  assign w_accept     = commit_valid && (r_state == ST_ARMED);
  assign w_idx_full   = (r_idx == {AW{1'b1}});
  assign w_is_halt    = (commit_kind == KIND_HALT);

  trace_rec_compare u_compare (
    .i_rec      (r_rec),
    .i_kind     (commit_kind),
    .i_pc       (commit_pc),
    .i_reg      (commit_reg),
    .i_value    (commit_value),
    .i_addr     (commit_addr),
    .o_mismatch (w_field_mm)
  );

  // A commit beyond the last addressable record is an extra commit, reported as a kind error.
  assign w_mm_vec   = w_field_mm | {{(FLAG_W-1){1'b0}}, w_idx_full};
  assign w_mismatch = |w_mm_vec;

  // Golden read address: look one record ahead of rec, two when consuming this cycle.
  always_comb begin
    w_gold_addr = '0;
    case (r_state)
      ST_PRIME0: w_gold_addr = '0;
      ST_PRIME1: w_gold_addr = AW'(1);
      ST_ARMED:  w_gold_addr = r_idx + AW'(1) + AW'(w_accept);
      default:   w_gold_addr = r_idx + AW'(1);
    endcase
  end

  assign gold_addr = w_gold_addr;

  // FSM plus the expected-record register and its index into the golden trace.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_PRIME0;
      r_rec   <= '0;
      r_idx   <= '0;
    end else begin
      case (r_state)
        ST_PRIME0: r_state <= ST_PRIME1;
        ST_PRIME1: begin
          r_rec   <= unpack_rec(gold_data);
          r_idx   <= '0;
          r_state <= ST_ARMED;
        end
        ST_ARMED: begin
          if (w_accept) begin
            r_rec <= unpack_rec(gold_data);
            r_idx <= r_idx + AW'(1);
            if ((w_mismatch && STOP_ON_FAIL) || w_is_halt) begin
              r_state <= ST_DONE;
            end
          end
        end
        default: r_state <= ST_DONE;
      endcase
    end
  end

  // Commit/error counters and the sticky first-mismatch debug capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_inst_count <= '0;
      r_err_count  <= '0;
      r_fail_index <= '0;
      r_fail_field <= '0;
      r_fail       <= 1'b0;
    end else if (w_accept) begin
      if (r_inst_count != 16'hFFFF) begin
        r_inst_count <= r_inst_count + 16'd1;
      end
      if (w_mismatch) begin
        if (r_err_count != 16'hFFFF) begin
          r_err_count <= r_err_count + 16'd1;
        end
        if (!r_fail) begin
          r_fail_index <= r_inst_count;
          r_fail_field <= w_mm_vec;
        end
        r_fail <= 1'b1;
      end
    end
  end

  assign done       = (r_state == ST_DONE);
  assign pass       = done && (r_err_count == 16'd0);
  assign fail       = r_fail;
  assign inst_count = r_inst_count;
  assign err_count  = r_err_count;
  assign fail_index = r_fail_index;
  assign fail_field = r_fail_field;

endmodule

// File: tb/tb_commit_trace_checker.sv
// Self-checking bench for commit_trace_checker. Two instances share the commit
// stream: dutA freezes on first mismatch, dutB keeps counting errors. Each has
// its own synchronous-read golden ROM built from the same trace array.
module tb_commit_trace_checker;

  logic        clk = 1'b0;
  logic        rst;
  logic        commitValid;
  logic [2:0]  commitKind;
  logic [15:0] commitPc;
  logic [3:0]  commitReg;
  logic [15:0] commitValue;
  logic [15:0] commitAddr;

  logic        readyA, readyB;
  logic [9:0]  goldAddrA, goldAddrB;
  logic [54:0] goldDataA, goldDataB;
  logic        doneA, doneB, passA, passB, failA, failB;
  logic [15:0] instA, instB, errA, errB, fidxA, fidxB;
  logic [4:0]  ffieldA, ffieldB;

  logic [54:0] goldMem [0:1023];
  logic [54:0] cq [$];

  int nChecks = 0;
  int nPass   = 0;

  wire [55:0] statA = {doneA, passA, failA, instA, errA, fidxA, ffieldA};
  wire [55:0] statB = {doneB, passB, failB, instB, errB, fidxB, ffieldB};

  always #5 clk = ~clk;

  // Golden ROMs: the record at the address presented is visible after the edge.
  always @(posedge clk) goldDataA <= goldMem[goldAddrA];
  always @(posedge clk) goldDataB <= goldMem[goldAddrB];

  commit_trace_checker #(.AW(10), .STOP_ON_FAIL(1'b1)) dutA (
    .clk(clk), .rst(rst), .commit_valid(commitValid), .commit_ready(readyA),
    .commit_kind(commitKind), .commit_pc(commitPc), .commit_reg(commitReg),
    .commit_value(commitValue), .commit_addr(commitAddr),
    .gold_addr(goldAddrA), .gold_data(goldDataA),
    .done(doneA), .pass(passA), .fail(failA), .inst_count(instA),
    .err_count(errA), .fail_index(fidxA), .fail_field(ffieldA)
  );

  commit_trace_checker #(.AW(10), .STOP_ON_FAIL(1'b0)) dutB (
    .clk(clk), .rst(rst), .commit_valid(commitValid), .commit_ready(readyB),
    .commit_kind(commitKind), .commit_pc(commitPc), .commit_reg(commitReg),
    .commit_value(commitValue), .commit_addr(commitAddr),
    .gold_addr(goldAddrB), .gold_data(goldDataB),
    .done(doneB), .pass(passB), .fail(failB), .inst_count(instB),
    .err_count(errB), .fail_index(fidxB), .fail_field(ffieldB)
  );

  function automatic logic [54:0] mkRec(input logic [2:0] k, input logic [15:0] pc,
                                        input logic [3:0] rd, input logic [15:0] v,
                                        input logic [15:0] a);
    return {k, pc, rd, v, a};
  endfunction

  // Reference: walk the queued commits against the golden list. Commit i is
  // checked against record i until checking stops; fields checked depend on the
  // expected kind, and an END record or unknown kind never matches.
  function automatic logic [55:0] modelStatus(input bit stopOnFail);
    logic        mDone = 1'b0, mFail = 1'b0;
    logic [15:0] mInst = 0, mErr = 0, mIdx = 0;
    logic [4:0]  mField = 0;
    for (int i = 0; i < cq.size(); i++) begin
      logic [54:0] g, c;
      logic [4:0]  flags;
      if (mDone) continue;
      g = goldMem[i];
      c = cq[i];
      flags = 5'b0;
      if (g[54:52] != c[54:52] || g[54:52] > 3'd4 || i == 1023) flags[0] = 1'b1;
      if (g[51:36] != c[51:36]) flags[1] = 1'b1;
      if ((g[54:52] == 3'd1 || g[54:52] == 3'd2) && g[35:32] != c[35:32]) flags[2] = 1'b1;
      if (g[54:52] inside {3'd1, 3'd2, 3'd3} && g[31:16] != c[31:16]) flags[3] = 1'b1;
      if ((g[54:52] == 3'd2 || g[54:52] == 3'd3) && g[15:0] != c[15:0]) flags[4] = 1'b1;
      if (flags != 0) begin
        if (!mFail) begin
          mIdx   = mInst;
          mField = flags;
        end
        mFail = 1'b1;
        if (mErr != 16'hFFFF) mErr++;
        if (stopOnFail) mDone = 1'b1;
      end
      if (mInst != 16'hFFFF) mInst++;
      if (c[54:52] == 3'd4) mDone = 1'b1;
    end
    return {mDone, mDone && (mErr == 0), mFail, mInst, mErr, mIdx, mField};
  endfunction

  task automatic clearTrace();
    cq.delete();
    for (int i = 0; i < 1024; i++) goldMem[i] = mkRec(3'd5, 16'h0, 4'h0, 16'h0, 16'h0);
  endtask

  task automatic loadBasicTrace();
    clearTrace();
    goldMem[0] = mkRec(3'd1, 16'h0000, 4'h1, 16'h0005, 16'h0000);
    goldMem[1] = mkRec(3'd3, 16'h0002, 4'h0, 16'h0005, 16'h0010);
    goldMem[2] = mkRec(3'd4, 16'h0004, 4'h0, 16'h0000, 16'h0000);
  endtask

  // Pulse reset for two cycles; returns at the negedge where reset drops.
  task automatic doReset();
    rst = 1'b1;
    commitValid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic drive(input logic [54:0] c);
    commitValid = 1'b1;
    {commitKind, commitPc, commitReg, commitValue, commitAddr} = c;
  endtask

  // Present a commit (called at a negedge), wait for ready, return after the accepting edge.
  task automatic send(input logic [54:0] c);
    int waitCnt = 0;
    drive(c);
    while (!readyA && waitCnt < 50) begin
      @(negedge clk);
      waitCnt++;
    end
    nChecks++;
    if (readyA !== 1'b1) $display("[TB] FAIL send_ready got %b required 1", readyA);
    else nPass++;
    cq.push_back(c);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    commitValid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    commitValid = 1'b0;
    {commitKind, commitPc, commitReg, commitValue, commitAddr} = '0;
    clearTrace();
    repeat (2) @(negedge clk);
    nChecks++;
    if (readyA !== 1'b0 || readyB !== 1'b0) $display("[TB] FAIL reset_ready got %b%b required 00", readyA, readyB);
    else nPass++;
    nChecks++;
    if (goldAddrA !== 10'd0) $display("[TB] FAIL reset_gold_addr got %0d required 0", goldAddrA);
    else nPass++;
    nChecks++;
    if (statA !== 56'd0) $display("[TB] FAIL reset_statusA got %h required 0", statA);
    else nPass++;
    nChecks++;
    if (statB !== 56'd0) $display("[TB] FAIL reset_statusB got %h required 0", statB);
    else nPass++;
  endtask

  task automatic test_pass_trace();
    loadBasicTrace();
    doReset();
    send(goldMem[0]);
    send(goldMem[1]);
    nChecks++;
    if (doneA !== 1'b0) $display("[TB] FAIL pass_done_early got %b required 0", doneA);
    else nPass++;
    send(goldMem[2]);
    idle(1);
    nChecks++;
    if (passA !== 1'b1 || doneA !== 1'b1 || instA !== 16'd3)
      $display("[TB] FAIL pass_result got pass=%b done=%b inst=%0d required 1 1 3", passA, doneA, instA);
    else nPass++;
    nChecks++;
    if (statB !== modelStatus(1'b0)) $display("[TB] FAIL pass_statusB got %h required %h", statB, modelStatus(1'b0));
    else nPass++;
  endtask

  task automatic test_stop_on_fail();
    loadBasicTrace();
    doReset();
    send(mkRec(3'd1, 16'h0000, 4'h1, 16'h0006, 16'h0000));
    send(goldMem[1]);
    send(goldMem[2]);
    idle(1);
    nChecks++;
    if (failA !== 1'b1 || fidxA !== 16'd0 || ffieldA !== 5'b01000 || doneA !== 1'b1 || instA !== 16'd1)
      $display("[TB] FAIL stop_debug got fail=%b idx=%0d field=%b done=%b inst=%0d required 1 0 01000 1 1",
               failA, fidxA, ffieldA, doneA, instA);
    else nPass++;
    nChecks++;
    if (statA !== modelStatus(1'b1)) $display("[TB] FAIL stop_statusA got %h required %h", statA, modelStatus(1'b1));
    else nPass++;
    nChecks++;
    if (statB !== modelStatus(1'b0)) $display("[TB] FAIL stop_statusB got %h required %h", statB, modelStatus(1'b0));
    else nPass++;
  endtask

  task automatic test_continue_on_fail();
    clearTrace();
    goldMem[0] = mkRec(3'd2, 16'h0000, 4'h2, 16'hBEEF, 16'h0020);
    goldMem[1] = mkRec(3'd4, 16'h0002, 4'h0, 16'h0000, 16'h0000);
    doReset();
    send(mkRec(3'd2, 16'h0000, 4'h2, 16'hBEEF, 16'h0022));
    send(goldMem[1]);
    idle(1);
    nChecks++;
    if (ffieldB !== 5'b10000 || errB !== 16'd1 || doneB !== 1'b1 || passB !== 1'b0 || instB !== 16'd2)
      $display("[TB] FAIL continue_result got field=%b err=%0d done=%b pass=%b inst=%0d required 10000 1 1 0 2",
               ffieldB, errB, doneB, passB, instB);
    else nPass++;
    nChecks++;
    if (statA !== modelStatus(1'b1)) $display("[TB] FAIL continue_statusA got %h required %h", statA, modelStatus(1'b1));
    else nPass++;
  endtask

  task automatic test_end_extra();
    clearTrace();
    goldMem[0] = mkRec(3'd1, 16'h0000, 4'h3, 16'h1234, 16'h0000);
    goldMem[1] = mkRec(3'd0, 16'h0002, 4'h0, 16'h0000, 16'h0000);
    goldMem[2] = mkRec(3'd5, 16'h0004, 4'h0, 16'h0000, 16'h0000);
    doReset();
    send(goldMem[0]);
    send(goldMem[1]);
    send(mkRec(3'd0, 16'h0004, 4'h0, 16'h0000, 16'h0000));
    idle(1);
    nChecks++;
    if (fidxB !== 16'd2 || ffieldB !== 5'b00001 || failB !== 1'b1)
      $display("[TB] FAIL end_extra got idx=%0d field=%b fail=%b required 2 00001 1", fidxB, ffieldB, failB);
    else nPass++;
    nChecks++;
    if (statA !== modelStatus(1'b1)) $display("[TB] FAIL end_statusA got %h required %h", statA, modelStatus(1'b1));
    else nPass++;
  endtask

  task automatic test_mid_reset();
    loadBasicTrace();
    doReset();
    send(goldMem[0]);
    send(goldMem[1]);
    commitValid = 1'b0;
    rst = 1'b1;
    #1;
    nChecks++;
    if (readyA !== 1'b0 || instA !== 16'd0 || goldAddrA !== 10'd0)
      $display("[TB] FAIL midreset_clear got ready=%b inst=%0d addr=%0d required 0 0 0", readyA, instA, goldAddrA);
    else nPass++;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    cq.delete();
    #1;
    nChecks++;
    if (readyA !== 1'b0 || goldAddrA !== 10'd0) $display("[TB] FAIL midreset_prime0 got ready=%b addr=%0d required 0 0", readyA, goldAddrA);
    else nPass++;
    @(negedge clk);
    nChecks++;
    if (readyA !== 1'b0 || goldAddrA !== 10'd1) $display("[TB] FAIL midreset_prime1 got ready=%b addr=%0d required 0 1", readyA, goldAddrA);
    else nPass++;
    @(negedge clk);
    nChecks++;
    if (readyA !== 1'b1) $display("[TB] FAIL midreset_armed got ready=%b required 1", readyA);
    else nPass++;
    send(goldMem[0]);
    send(goldMem[1]);
    send(goldMem[2]);
    idle(1);
    nChecks++;
    if (passA !== 1'b1 || instA !== 16'd3) $display("[TB] FAIL midreset_replay got pass=%b inst=%0d required 1 3", passA, instA);
    else nPass++;
  endtask

  task automatic test_prime_hold();
    loadBasicTrace();
    doReset();
    drive(goldMem[0]);
    #1;
    nChecks++;
    if (instA !== 16'd0 || readyA !== 1'b0) $display("[TB] FAIL hold_prime0 got inst=%0d ready=%b required 0 0", instA, readyA);
    else nPass++;
    @(negedge clk);
    nChecks++;
    if (instA !== 16'd0 || readyA !== 1'b0) $display("[TB] FAIL hold_prime1 got inst=%0d ready=%b required 0 0", instA, readyA);
    else nPass++;
    @(negedge clk);
    send(goldMem[0]);
    nChecks++;
    if (instA !== 16'd1 || errA !== 16'd0) $display("[TB] FAIL hold_accept got inst=%0d err=%0d required 1 0", instA, errA);
    else nPass++;
    send(goldMem[1]);
    send(goldMem[2]);
    idle(1);
    nChecks++;
    if (statA !== modelStatus(1'b1)) $display("[TB] FAIL hold_statusA got %h required %h", statA, modelStatus(1'b1));
    else nPass++;
  endtask

  task automatic test_random(input int iter);
    int n;
    logic [54:0] c;
    clearTrace();
    n = $urandom_range(6, 24);
    for (int i = 0; i < n; i++) begin
      goldMem[i] = mkRec(3'($urandom_range(0, 3)), 16'($urandom), 4'($urandom), 16'($urandom), 16'($urandom));
    end
    goldMem[n] = mkRec(3'd4, 16'($urandom), 4'($urandom), 16'($urandom), 16'($urandom));
    doReset();
    for (int i = 0; i <= n + 1; i++) begin
      c = goldMem[i];
      if ($urandom_range(0, 3) == 0) begin
        case ($urandom_range(0, 4))
          0: c[54:52] = 3'($urandom_range(0, 4));
          1: c[51:36] = c[51:36] ^ 16'h0001;
          2: c[35:32] = c[35:32] ^ 4'h8;
          3: c[31:16] = c[31:16] ^ 16'h0100;
          default: c[15:0] = c[15:0] ^ 16'h4000;
        endcase
      end
      send(c);
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
    end
    idle(1);
    nChecks++;
    if (statA !== modelStatus(1'b1)) $display("[TB] FAIL random%0d_statusA got %h required %h", iter, statA, modelStatus(1'b1));
    else nPass++;
    nChecks++;
    if (statB !== modelStatus(1'b0)) $display("[TB] FAIL random%0d_statusB got %h required %h", iter, statB, modelStatus(1'b0));
    else nPass++;
  endtask

  initial begin
    test_reset();
    test_pass_trace();
    test_stop_on_fail();
    test_continue_on_fail();
    test_end_extra();
    test_mid_reset();
    test_prime_hold();
    for (int k = 0; k < 6; k++) test_random(k);
    $display("[TB] %0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule

// File: doc/commit_trace_checker.md
# commit_trace_checker

Hardware reader for the per-instruction commit trace produced by the single-cycle CPU (pc, register write, load, store, branch/NOP, halt). It compares each commit, in order, against a golden trace held in a synchronous-read ROM/RAM. It raises `pass` or `fail` when the program halts, latching the first mismatch for debug. It sits beside `cpu` in the system top and in FPGA self-check builds, replacing file-based trace diffing.

## Interface
- `AW`, 10: golden-trace address width (max 2^AW records).
- `STOP_ON_FAIL`, 1: 1 = freeze on first mismatch; 0 = keep checking and count errors.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous and active-high; clears all state.
- `commit_valid` in 1: a commit record is presented this cycle.
- `commit_ready` out 1: the checker can accept a commit. A commit is accepted when `commit_valid & commit_ready`. The source holds all `commit_*` stable until accepted.
- `commit_kind` in 3: 0 NOP/branch, 1 REG, 2 LD, 3 ST, 4 HALT.
- `commit_pc` in 16: PC of the committing instruction.
- `commit_reg` in 4: destination register (REG/LD).
- `commit_value` in 16: write data (REG/LD) or store data (ST).
- `commit_addr` in 16: memory address (LD/ST).
- `gold_addr` out AW: golden memory read address (combinational).
- `gold_data` in 55: record captured at the previous edge, laid out as [54:52] kind, [51:36] pc, [35:32] reg, [31:16] value, [15:0] addr. Kind 5 = END.
- `done` out 1: checking finished (halt accepted or frozen on fail).
- `pass` out 1: `done` and `err_count == 0`.
- `fail` out 1: at least one mismatch seen (sticky).
- `inst_count` out 16: accepted commits.
- `err_count` out 16: mismatching commits, saturating at 0xFFFF.
- `fail_index` out 16: `inst_count` value of the first mismatching commit.
- `fail_field` out 5: first-mismatch field flags {addr, value, reg, pc, kind}.

## Operation
- States: PRIME0, PRIME1, ARMED, DONE.
  - PRIME0: `gold_addr`=0, go to PRIME1.
  - PRIME1: `gold_addr`=1, `rec` <= `gold_data` (record 0), `idx` <= 0, go to ARMED.
  - ARMED: `commit_ready`=1.
  - DONE: `commit_ready`=1; commits are accepted and ignored, no counters change.
- ARMED, pointer rule: `gold_addr = idx + 1 + accept`.
  - Invariant: `gold_data` equals record `idx+1` whenever in ARMED.
  - On accept: `rec` <= `gold_data`, `idx` <= `idx+1`.
- Compare, by expected kind (`rec.kind`):
  - Kind must equal `commit_kind`, or the kind flag is set.
  - PC is always compared.
  - REG compares reg and value. LD compares reg, value and addr. ST compares value and addr. NOP and HALT compare PC only.
  - Expected END, or `idx` = 2^AW-1 on accept: kind mismatch ("extra commit").
- On mismatch:
  - `err_count`++ (saturating), `fail`=1.
  - If this is the first mismatch, latch `fail_index` and `fail_field`.
  - If `STOP_ON_FAIL`=1, go to DONE.
- Any accepted `commit_kind`=HALT goes to DONE after its compare, whether it matched or not.
- `inst_count` increments on every accept in ARMED, saturating.

## Timing
- Reset values: `commit_ready`=0, `gold_addr`=0, `done`=0, `pass`=0, `fail`=0, all counts 0, `fail_index`=0, `fail_field`=0, state PRIME0.
- `commit_ready` rises 2 cycles after `rst` deasserts. The CPU's 2-edge reset window covers the priming.
- Throughput is one commit per cycle in ARMED. Back-to-back accepts are required to work.
- Compare is combinational on the accept cycle. All flags and counters update at that edge.
- `done`, `pass` and `fail` are visible the cycle after the HALT or frozen-mismatch accept.
- `rst` asserted mid-run immediately clears all state and restarts priming. The golden pointer restarts at 0.
- A commit with `commit_valid` high during PRIME is not accepted; the source holds it.

## Structure
- Shared package `trace_pkg`:
  - kind enum (NOP, REG, LD, ST, HALT, END);
  - record field bit positions and `REC_W`=55;
  - state enum.
- The compare is a natural sub-module, `trace_rec_compare`. It is purely combinational: (rec, commit) -> 5-bit field-mismatch vector.
- The FSM, pointer and counters live in the top.

## Test plan
- Golden trace = REG r1=0x0005 @0x0000, ST [0x0010]=0x0005 @0x0002, HALT @0x0004, with matching back-to-back commits. Expect `pass`=1, `inst_count`=3, `done` one cycle after the HALT accept.
- Same trace, REG value 0x0006, `STOP_ON_FAIL`=1. Expect `fail`=1, `fail_index`=0, `fail_field`=5'b01000, `done`=1, later commits ignored.
- LD r2=0xBEEF addr 0x0020 expected, commit addr 0x0022, `STOP_ON_FAIL`=0. Expect `fail_field`=5'b10000, `err_count`=1, checking continues to HALT with `pass`=0.
- Golden ends with END after 2 records; a third non-HALT commit is accepted. Expect a kind mismatch with `fail_index`=2.
- Assert `rst` after 2 accepts, release, and replay the full trace. Expect `commit_ready` low for exactly 2 cycles, `gold_addr` 0 then 1, and final `pass`=1 with `inst_count`=3.
- Present `commit_valid` during PRIME0/PRIME1. Expect no accept and no counter change until ARMED, then acceptance of the held record.
